fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 WIDTH, 32, address/data width in bits.
REQ-002 RESET_ADDR, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 redirect_valid  in  1  branch/jump taken this cycle.
REQ-006 redirect_addr  in  WIDTH  new fetch target.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  WIDTH  fetch address, valid while imem_req=1.
REQ-009 imem_ready  in  1  memory accepts request when imem_req&imem_ready.
REQ-010 imem_rvalid  in  1  read data valid, earliest one cycle after acceptance.
REQ-011 imem_rdata  in  WIDTH  fetched instruction word.
REQ-012 instr_valid  out  1  instruction buffer holds a word.
REQ-013 instr_ready  in  1  decode consumes buffer (low = stall, e.g. load awaiting dmem).
REQ-014 instr  out  WIDTH  buffered instruction.
REQ-015 instr_pc  out  WIDTH  address of buffered instruction.
REQ-016 fetch_fault  out  1  misaligned redirect flag (see Configuration).

Function
REQ-017 States IDLE, REQ, WAIT, DRAIN, HALT; one outstanding fetch maximum.
REQ-018 IDLE -> REQ unconditionally on first clock after reset release.
REQ-019 REQ: imem_req=buf_free, where buf_free = !instr_valid | instr_ready; imem_addr=pc.
REQ-020 REQ with imem_req&imem_ready -> WAIT; pc <= pc+4 (mod 2^WIDTH, wraps from 32'hFFFF_FFFC to 0); req_pc <= pc.
REQ-021 imem_addr stable while imem_req=1 and imem_ready=0, except on redirect.
REQ-022 WAIT with imem_rvalid: instr <= imem_rdata, instr_pc <= req_pc, instr_valid <= 1; -> REQ.
REQ-023 instr_valid clears cycle after instr_valid&instr_ready unless refilled same cycle; buffer holds value while instr_ready=0.
REQ-024 Redirect has highest priority: pc <= redirect_addr, instr_valid <= 0 next cycle.
REQ-025 Redirect in REQ without acceptance -> REQ; next cycle imem_addr=redirect_addr (latency 1).
REQ-026 Redirect in REQ with same-cycle acceptance, or in WAIT without imem_rvalid -> DRAIN.
REQ-027 Redirect in WAIT with same-cycle imem_rvalid: response discarded, -> REQ.
REQ-028 DRAIN: imem_req=0; next imem_rvalid discarded, -> REQ; further redirects update pc, stay DRAIN.
REQ-029 Redirect in IDLE loads pc; IDLE -> REQ still taken.

Reset
REQ-030 On rst low: state=IDLE, pc=RESET_ADDR, req_pc=0, instr=0, instr_pc=0, instr_valid=0, imem_req=0, fetch_fault=0, immediately and independent of clk.
REQ-031 Reset mid-fetch abandons outstanding request; late imem_rvalid after reset release, before first acceptance, ignored.

Configuration
REQ-032 Macro FETCH_CTRL_ALIGN_CHECK_EN.
REQ-033 Defined: redirect with redirect_addr[1:0]!=0 -> HALT, fetch_fault=1 sticky, imem_req=0, instr_valid=0; exit only via reset; pending response ignored.
REQ-034 Undefined: redirect_addr[1:0] forced to 0, HALT unreachable, fetch_fault tied 0.

Verification
REQ-035 Reset release, imem_ready=1, rvalid 1 cycle later, instr_ready=1 -> imem_addr 0x0,0x4,0x8 on alternating cycles; instr_pc follows same sequence.
REQ-036 instr_ready=0 with buffer full (instr_pc=0x4) -> imem_req=0, instr/instr_pc held; instr_ready=1 -> request 0x8 same cycle.
REQ-037 Redirect to 0x100 in WAIT, rvalid 3 cycles later -> that word dropped, next imem_addr=0x100, instr_valid=0 throughout.
REQ-038 imem_ready=0 for 4 cycles at 0x8, redirect to 0x40 on cycle 2 -> imem_addr 0x8 then 0x40, no 0x8 acceptance.
REQ-039 RESET_ADDR=32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-040 Redirect to 0x102 -> with macro: fetch_fault=1, imem_req=0 until reset; without: next imem_addr=0x100.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_ctrl : single-outstanding instruction fetch with one-word buffer.  |
// | Optional misaligned-redirect halt: FETCH_CTRL_ALIGN_CHECK_EN             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] req_pc, req_pc_nxt;
    logic [WIDTH-1:0] instr_q, instr_nxt;
    logic [WIDTH-1:0] ipc_q, ipc_nxt;
    logic             valid_q, valid_nxt;
    logic             buf_free;
    logic             accept;
    logic             misaligned;
    logic [WIDTH-1:0] target;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    assign target     = redirect_addr;
    assign misaligned = redirect_valid && (redirect_addr[1:0] != 2'b00);
`else
    assign target     = redirect_addr & ~WIDTH'(3);
    assign misaligned = 1'b0;
`endif

    assign buf_free    = !valid_q || instr_ready;
    assign imem_req    = (state == S_REQ) && buf_free;
    assign imem_addr   = pc;
    assign accept      = imem_req && imem_ready;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    // HALT is sticky until reset, so it doubles as the fault flag.
    assign fetch_fault = (state == S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_ADDR;
            req_pc  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            req_pc  <= req_pc_nxt;
            instr_q <= instr_nxt;
            ipc_q   <= ipc_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        req_pc_nxt = req_pc;
        instr_nxt  = instr_q;
        ipc_nxt    = ipc_q;
        valid_nxt  = valid_q;

        if (valid_q && instr_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (accept) begin
                    state_nxt  = S_WAIT;
                    pc_nxt     = pc + WIDTH'(4);
                    req_pc_nxt = pc;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                    instr_nxt = imem_rdata;
                    ipc_nxt   = req_pc;
                    valid_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase

        // Redirect overrides everything above; an in-flight fetch must be drained.
        if (redirect_valid && state != S_HALT) begin
            pc_nxt    = target;
            valid_nxt = 1'b0;
            case (state)
                S_REQ:   state_nxt = accept ? S_DRAIN : S_REQ;
                S_WAIT:  state_nxt = imem_rvalid ? S_REQ : S_DRAIN;
                default: ;
            endcase
            if (misaligned) begin
                state_nxt = S_HALT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// tb_fetch_ctrl: scoreboard bench with a one-outstanding memory responder.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_ready, imem_rvalid, instr_ready;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, fetch_fault;
    logic [31:0] imem_addr, instr, instr_pc;
    logic        imem_req2, instr_valid2, fetch_fault2;
    logic [31:0] imem_addr2, instr2, instr_pc2;

    always #5 clk = ~clk;

    fetch_ctrl #(.WIDTH(32), .RESET_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
    );

    fetch_ctrl #(.WIDTH(32), .RESET_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .instr(instr2), .instr_pc(instr_pc2), .fetch_fault(fetch_fault2)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    bit          ctl_ready, ctl_iready, force_rvalid;
    int          ctl_lat;
    bit          pend, pend_kill;
    logic [31:0] pend_addr;
    int          pend_cnt;
    logic [31:0] exp_pc, exp_pc2;
    int          n_acc, cyc, last_acc_cyc;
    bit          trk2, chk_alt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        instr_ready    = 1'b0;
        pend           = 1'b0;
        pend_kill      = 1'b0;
        force_rvalid   = 1'b0;
        exp_q.delete();
        exp_pc  = 32'h0;
        exp_pc2 = 32'hFFFF_FFFC;
        n_acc   = 0;
        trk2    = 1'b0;
        chk_alt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive inputs at negedge, observe #1 later, update scoreboard.
    task automatic step(input bit redir, input logic [31:0] raddr);
        bit          delivered;
        bit          acc;
        logic [31:0] del_addr;
        exp_t        e;
        @(negedge clk);
        cyc++;
        delivered      = 1'b0;
        del_addr       = '0;
        redirect_valid = redir;
        redirect_addr  = raddr;
        imem_ready     = ctl_ready;
        instr_ready    = ctl_iready;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'hDEAD_BEEF;
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                del_addr    = pend_addr;
                delivered   = 1'b1;
                pend        = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (force_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
        end
        #1;
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_instr", {31'b0, instr_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.data);
            end
        end
        acc = imem_req && imem_ready;
        if (trk2 && imem_req2 && imem_ready) begin
            check("wrap_fetch_addr", imem_addr2, exp_pc2);
            exp_pc2 = exp_pc2 + 32'd4;
        end
        if (acc) begin
            check("fetch_addr", imem_addr, exp_pc);
            if (chk_alt && n_acc > 0) check("accept_spacing", cyc - last_acc_cyc, 32'd2);
            last_acc_cyc = cyc;
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = ctl_lat;
            pend_kill = redir;
            exp_pc    = exp_pc + 32'd4;
            n_acc++;
        end
        if (delivered && !pend_kill && !redir) begin
            e.pc   = del_addr;
            e.data = mem_word(del_addr);
            exp_q.push_back(e);
        end
        if (redir) begin
            if (pend) pend_kill = 1'b1;
            exp_q.delete();
            exp_pc = raddr & ~32'd3;
            trk2   = 1'b0;
        end
    endtask

    task automatic run_until_acc(input int target, input int budget);
        int k;
        k = 0;
        while (n_acc < target && k < budget) begin
            step(1'b0, '0);
            k++;
        end
        if (n_acc < target) check("accept_timeout", n_acc, target);
    endtask

    initial begin
        cyc = 0;
        last_acc_cyc = 0;
        ctl_lat = 1;
        do_reset();
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'h0);

        // Streaming: 0,4,8 on alternating cycles; wrap instance 0xFFFFFFFC then 0
        ctl_ready = 1; ctl_iready = 1; ctl_lat = 1;
        trk2 = 1; chk_alt = 1;
        run_until_acc(4, 20);
        check("wrap_tracked_two", exp_pc2, 32'h0000_000C);
        repeat (2) step(1'b0, '0);
        chk_alt = 0;

        // Decode stall with 0x4 buffered
        do_reset();
        ctl_ready = 1; ctl_iready = 1; ctl_lat = 1;
        run_until_acc(2, 20);
        ctl_iready = 0;
        step(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0);
            check("stall_req", {31'b0, imem_req}, 32'h0);
            check("stall_valid", {31'b0, instr_valid}, 32'h1);
            check("stall_pc", instr_pc, 32'h4);
            check("stall_instr", instr, mem_word(32'h4));
        end
        ctl_iready = 1;
        step(1'b0, '0);
        check("unstall_req", {31'b0, imem_req}, 32'h1);
        check("unstall_addr", imem_addr, 32'h8);

        // Redirect during WAIT, response 3 cycles later is dropped
        do_reset();
        ctl_ready = 1; ctl_iready = 1; ctl_lat = 4;
        run_until_acc(1, 20);
        step(1'b1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0);
            check("drain_req", {31'b0, imem_req}, 32'h0);
            check("drain_valid", {31'b0, instr_valid}, 32'h0);
        end
        step(1'b0, '0);
        check("post_drain_req", {31'b0, imem_req}, 32'h1);
        check("post_drain_addr", imem_addr, 32'h100);
        check("post_drain_valid", {31'b0, instr_valid}, 32'h0);
        ctl_lat = 1;
        run_until_acc(3, 20);

        // Back-pressure at 0x8 with redirect to 0x40 on the second stalled cycle
        do_reset();
        ctl_ready = 1; ctl_iready = 1; ctl_lat = 1;
        run_until_acc(2, 20);
        ctl_ready = 0;
        step(1'b0, '0);
        step(1'b0, '0);
        check("bp_addr_c1", imem_addr, 32'h8);
        step(1'b1, 32'h40);
        check("bp_addr_c2", imem_addr, 32'h8);
        check("bp_req_c2", {31'b0, imem_req}, 32'h1);
        step(1'b0, '0);
        check("bp_addr_c3", imem_addr, 32'h40);
        step(1'b0, '0);
        check("bp_addr_c4", imem_addr, 32'h40);
        check("bp_no_accept", n_acc, 32'd2);
        ctl_ready = 1;
        run_until_acc(4, 20);

        // Asynchronous reset with a full buffer, then a stray rvalid after release
        ctl_iready = 0;
        repeat (3) step(1'b0, '0);
        check("pre_reset_valid", {31'b0, instr_valid}, 32'h1);
        rst = 1'b0;
        #1;
        check("async_rst_req", {31'b0, imem_req}, 32'h0);
        check("async_rst_valid", {31'b0, instr_valid}, 32'h0);
        check("async_rst_instr", instr, 32'h0);
        check("async_rst_pc", instr_pc, 32'h0);
        do_reset();
        ctl_ready = 1; ctl_iready = 1; ctl_lat = 1;
        force_rvalid = 1;
        step(1'b0, '0);
        force_rvalid = 0;
        step(1'b0, '0);
        check("late_rvalid_ignored", {31'b0, instr_valid}, 32'h0);
        run_until_acc(3, 20);

        // Misaligned redirect to 0x102
        do_reset();
        ctl_ready = 1; ctl_iready = 1; ctl_lat = 1;
        run_until_acc(2, 20);
        step(1'b1, 32'h102);
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0);
            check("halt_fault", {31'b0, fetch_fault}, 32'h1);
            check("halt_req", {31'b0, imem_req}, 32'h0);
            check("halt_valid", {31'b0, instr_valid}, 32'h0);
        end
`else
        step(1'b0, '0);
        check("align_req", {31'b0, imem_req}, 32'h1);
        check("align_addr", imem_addr, 32'h100);
        check("align_fault", {31'b0, fetch_fault}, 32'h0);
        run_until_acc(5, 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
